// File: rtl/console_ctrl_if.sv
// Console character/video-RAM bus.
// Groups the character input handshake, the clear request and the
// video RAM write port of console_ctrl.
//   char_i     [7:0]  character code toward the console
//   char_valid        char_i is valid
//   char_ready        console accepts char_i this cycle
//   clear_i           single-cycle request to clear the whole screen
//   we_vram           video RAM write enable
//   addr_wr    [10:0] video RAM write address (row*screenW+col)
//   data_wr    [7:0]  video RAM write data
// master: character source / RAM owner side; slave: console_ctrl.
interface console_ctrl_if;
   logic [7:0]  char_i;
   logic        char_valid;
   logic        char_ready;
   logic        clear_i;
   logic        we_vram;
   logic [10:0] addr_wr;
   logic [7:0]  data_wr;

   modport master (
      output char_i, char_valid, clear_i,
      input  char_ready, we_vram, addr_wr, data_wr
   );

   modport slave (
      input  char_i, char_valid, clear_i,
      output char_ready, we_vram, addr_wr, data_wr
   );
endinterface

// File: rtl/console_ctrl.sv
// Text console controller: turns a stream of character codes into video
// RAM writes and tracks the cursor. Handles printable text, BS, CR, LF, FF
// (clear), line overflow, row wrap and full-screen clear.
// Ports:
//   px_clk            pixel clock, all state on rising edge
//   rst_n             asynchronous active-low reset
//   bus (slave)       character handshake, clear request, video RAM write
//   cursor_x   [5:0]  cursor column, 0..screenW-1
//   cursor_y   [4:0]  cursor row, 0..screenH-1
//   busy              high whenever the FSM is not IDLE
// Optional feature: define WRAP_CLEAR_EN to blank the new row after every
// newline (LF, line overflow, row wrap). Undefined: newline moves the
// cursor only and the old text stays on screen.
// Write timing: every video RAM write is issued on a clock edge from the
// current state, so a state's writes appear one cycle behind it. CLEAR and
// CLRLINE therefore occupy one extra state cycle after their last write.
module console_ctrl #(
   parameter int unsigned screenW = 40,
   parameter int unsigned screenH = 30
) (
   input  logic            px_clk,
   input  logic            rst_n,
   console_ctrl_if.slave   bus,
   output logic [5:0]      cursor_x,
   output logic [4:0]      cursor_y,
   output logic            busy
);

   localparam int unsigned AW    = 11;
   localparam int unsigned CELLS = screenW * screenH;
   localparam int unsigned CW    = $clog2(CELLS + 1);

   localparam logic [AW-1:0] W_A     = AW'(screenW);
   localparam logic [CW-1:0] W_C     = CW'(screenW);
   localparam logic [CW-1:0] CELLS_C = CW'(CELLS);
   localparam logic [5:0]    COL_MAX = 6'(screenW - 1);
   localparam logic [4:0]    ROW_MAX = 5'(screenH - 1);
   localparam logic [7:0]    BLANK   = 8'h20;

`ifdef WRAP_CLEAR_EN
   localparam bit WRAP_CLEAR = 1'b1;
`else
   localparam bit WRAP_CLEAR = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      CLRLINE,
      CLEAR
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [7:0]      char_q, char_d;
   logic            pend_q, pend_d;
   logic [5:0]      cx_d;
   logic [4:0]      cy_d;
   logic            we_d;
   logic [AW-1:0]   addr_d;
   logic [7:0]      data_d;
   logic            nl;
   logic            go_clear;
   logic [AW-1:0]   row_base;
   logic            print_i;
   logic            print_q;

   assign row_base = AW'(cursor_y) * W_A;
   assign print_i  = (bus.char_i >= 8'h20) && (bus.char_i <= 8'h7E);
   assign print_q  = (char_q >= 8'h20) && (char_q <= 8'h7E);

   // State, cursor and registered outputs.
   always_ff @(posedge px_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= CLEAR;
         cnt_q          <= '0;
         char_q         <= '0;
         pend_q         <= 1'b0;
         cursor_x       <= '0;
         cursor_y       <= '0;
         bus.we_vram    <= 1'b0;
         bus.addr_wr    <= '0;
         bus.data_wr    <= '0;
         bus.char_ready <= 1'b0;
         busy           <= 1'b1;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         char_q         <= char_d;
         pend_q         <= pend_d;
         cursor_x       <= cx_d;
         cursor_y       <= cy_d;
         bus.we_vram    <= we_d;
         bus.addr_wr    <= addr_d;
         bus.data_wr    <= data_d;
         bus.char_ready <= (state_d == IDLE) && !pend_d;
         busy           <= (state_d != IDLE);
      end
   end

   // Next-state, cursor and write-port logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      char_d   = char_q;
      pend_d   = pend_q;
      cx_d     = cursor_x;
      cy_d     = cursor_y;
      we_d     = 1'b0;
      addr_d   = bus.addr_wr;
      data_d   = bus.data_wr;
      nl       = 1'b0;
      go_clear = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.clear_i || pend_q) begin
               // Clear wins over a character offered in the same cycle.
               state_d = CLEAR;
               cnt_d   = '0;
            end else if (bus.char_valid && bus.char_ready) begin
               char_d  = bus.char_i;
               state_d = WRITE;
               // Issue the cell write now so it is visible in the WRITE cycle.
               if (print_i) begin
                  we_d   = 1'b1;
                  addr_d = row_base + AW'(cursor_x);
                  data_d = bus.char_i;
               end else if (bus.char_i == 8'h08 && cursor_x != 6'd0) begin
                  we_d   = 1'b1;
                  addr_d = row_base + AW'(cursor_x - 6'd1);
                  data_d = BLANK;
               end
            end
         end

         WRITE: begin
            pend_d = pend_q | bus.clear_i;
            if (print_q) begin
               if (cursor_x == COL_MAX) nl = 1'b1;
               else                     cx_d = cursor_x + 6'd1;
            end else begin
               case (char_q)
                  8'h08:   if (cursor_x != 6'd0) cx_d = cursor_x - 6'd1;
                  8'h0D:   cx_d = '0;
                  8'h0A:   nl = 1'b1;
                  8'h0C:   go_clear = 1'b1;
                  default: ;
               endcase
            end
            if (nl) begin
               cx_d = '0;
               cy_d = (cursor_y == ROW_MAX) ? 5'd0 : cursor_y + 5'd1;
            end
            cnt_d = '0;
            if (go_clear)              state_d = CLEAR;
            else if (nl && WRAP_CLEAR) state_d = CLRLINE;
            else if (pend_d)           state_d = CLEAR;
            else                       state_d = IDLE;
         end

         CLRLINE: begin
            pend_d = pend_q | bus.clear_i;
            if (cnt_q < W_C) begin
               // cursor_y already holds the new row here.
               we_d   = 1'b1;
               addr_d = row_base + AW'(cnt_q);
               data_d = BLANK;
               cnt_d  = cnt_q + CW'(1);
            end else begin
               cnt_d   = '0;
               state_d = pend_d ? CLEAR : IDLE;
            end
         end

         CLEAR: begin
            pend_d = 1'b0;
            if (cnt_q < CELLS_C) begin
               we_d   = 1'b1;
               addr_d = AW'(cnt_q);
               data_d = BLANK;
               cnt_d  = cnt_q + CW'(1);
            end else begin
               cnt_d   = '0;
               cx_d    = '0;
               cy_d    = '0;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = CLEAR;
            cnt_d   = '0;
         end
      endcase

      // A clear that is being started now is no longer pending.
      if (state_d == CLEAR) pend_d = 1'b0;
   end

endmodule

// File: doc/console_ctrl.md
CONSOLE_CTRL -- requirements
Module: console_ctrl

Interface
REQ-001 Parameter screenW, default 40, characters per text row.
REQ-002 Parameter screenH, default 30, text rows per screen.
REQ-003 px_clk  in  1  pixel clock; all state on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 char_i  in  8  character code to place on console.
REQ-006 char_valid  in  1  char_i is valid.
REQ-007 char_ready  out  1  block accepts char_i this cycle; transfer when char_valid and char_ready both high.
REQ-008 clear_i  in  1  single-cycle request to clear whole screen.
REQ-009 we_vram  out  1  video RAM write enable.
REQ-010 addr_wr  out  11  video RAM write address, row*screenW+col.
REQ-011 data_wr  out  8  video RAM write data.
REQ-012 cursor_x  out  6  current cursor column, 0..screenW-1.
REQ-013 cursor_y  out  5  current cursor row, 0..screenH-1.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, WRITE, CLRLINE, CLEAR; char_ready SHALL be high only in IDLE with no pending clear.
REQ-016 IDLE: clear_i or pending clear -> CLEAR (priority over char_valid); else accepted char -> WRITE; else stay.
REQ-017 WRITE, exactly one cycle after acceptance: 0x20..0x7E -> we_vram=1, addr=cursor, data=char, col+1; 0x08 -> if col>0, col-1 and write 0x20 at new col, else no write; 0x0D -> col=0, no write; 0x0A -> newline, no write; 0x0C -> CLEAR; other codes -> no write; then IDLE.
REQ-018 Column past screenW-1 after printable write SHALL cause newline in the same update.
REQ-019 Newline: col=0, row+1; row screenH-1 wraps to 0.
REQ-020 Newline SHALL enter CLRLINE when WRAP_CLEAR_EN defined (REQ-029), else return to IDLE.
REQ-021 CLRLINE: screenW consecutive cycles, we_vram=1, data 0x20, addr new_row*screenW+0..screenW-1 ascending; then IDLE.
REQ-022 CLEAR: screenW*screenH consecutive cycles, we_vram=1, data 0x20, addr 0..1199 ascending (defaults); then cursor (0,0), IDLE.
REQ-023 we_vram SHALL be low whenever no write is defined above; addr_wr/data_wr don't-care when low.
REQ-024 clear_i during WRITE or CLRLINE SHALL be latched as pending and serviced on next IDLE; clear_i during CLEAR ignored.
REQ-025 cursor_x/cursor_y registered, update the cycle after the write that moves them.
REQ-026 addr_wr arithmetic 11 bits unsigned, no overflow for screenW*screenH<=2048.

Reset
REQ-027 rst_n low: state CLEAR with counter 0, cursor (0,0), we_vram=0, addr_wr=0, data_wr=0, char_ready=0, busy=1, pending clear 0.
REQ-028 After rst_n release, full CLEAR of REQ-022 runs before first char_ready; reset mid-operation aborts immediately to REQ-027.

Configuration
REQ-029 Macro WRAP_CLEAR_EN: defined -> every newline (LF, line overflow, wrap) clears new row via CLRLINE; undefined -> CLRLINE unreachable, newline moves cursor only, old text stays.

Verification
REQ-030 Release reset -> 1200 writes of 0x20, addr 0..1199 consecutive, then char_ready=1, cursor (0,0).
REQ-031 Send 'A' (0x41) at (0,0) -> next cycle we_vram=1, addr 0, data 0x41; then cursor_x=1.
REQ-032 Cursor (39,2), send 0x42 -> write addr 119; cursor (0,3); with WRAP_CLEAR_EN 40 writes 0x20 addr 120..159.
REQ-033 Cursor (5,29), send 0x0A -> cursor (0,0); with WRAP_CLEAR_EN writes addr 0..39; without, no writes.
REQ-034 Cursor (0,4) send 0x08 -> no write, cursor unchanged; cursor (3,4) send 0x08 -> write 0x20 at addr 162, cursor (2,4).
REQ-035 clear_i and char_valid same cycle in IDLE -> CLEAR runs, char not accepted until CLEAR ends; clear_i during CLRLINE -> CLEAR starts right after CLRLINE.
